// File: rtl/jk_reg_bank.sv
// WIDTH-bit register bank with per-bit JK/D/T or whole-word COUNT behaviour,
// parallel load, change/carry pulses and a saturating change-event counter.
module jk_reg_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic             changed,
    output logic             carry,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             cnt_sat
);

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_D     = 2'b01;
    localparam logic [1:0] MODE_T     = 2'b10;
    localparam logic [1:0] MODE_COUNT = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] r_q;
    logic             r_changed;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;

    logic [WIDTH-1:0] w_q_next;
    logic             w_chg;
    logic             w_carry;
    logic [CNT_W-1:0] w_cnt_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        w_q_next = r_q;
        if (load) begin
            w_q_next = load_data;
        end else if (en) begin
            case (mode)
                MODE_JK:    w_q_next = (j & ~r_q) | (~k & r_q);
                MODE_D:     w_q_next = j;
                MODE_T:     w_q_next = r_q ^ j;
                MODE_COUNT: w_q_next = r_q + WIDTH'(1);
                default:    w_q_next = r_q;
            endcase
        end
    end

    assign w_chg     = (w_q_next != r_q);
    assign w_carry   = en && !load && (mode == MODE_COUNT) && (&r_q);
    assign w_cnt_inc = sat_inc(r_cnt);

    // Register stage: every output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= '0;
            r_changed <= 1'b0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_changed <= w_chg;
            r_carry   <= w_carry;
            if (clr_cnt) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (w_chg) begin
                r_cnt <= w_cnt_inc;
                r_sat <= r_sat | (w_cnt_inc == CNT_MAX);
            end
        end
    end

    assign q       = r_q;
    assign changed = r_changed;
    assign carry   = r_carry;
    assign chg_cnt = r_cnt;
    assign cnt_sat = r_sat;

endmodule
